// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first one-bit-per-clock adder with valid/ready in and out; define SERIAL_ADD_OVF_EN for an ovf output
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_sh;
  logic [WIDTH-2:0] r_s;
  logic [CW-1:0] r_cnt;
  logic r_c, w_h, w_s, w_co, w_last;
  assign w_h = r_a[0] ^ r_b[0];
  assign w_s = w_h ^ r_c;
  assign w_co = (r_a[0] & r_b[0]) | (w_h & r_c);
  assign w_sh = {w_s, r_s};
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  // next state: accept in IDLE, leave RUN on the last bit, release DONE on out_ready
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && in_valid) ? RUN :
             (r_state == RUN && w_last) ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // datapath: load operands, shift one bit per RUN cycle, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_c <= 1'b0;
      r_cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
      r_c <= cin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_s <= w_sh[WIDTH-1:1];
      r_c <= w_co;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        sum <= w_sh;
        cout <= w_co;
`ifdef SERIAL_ADD_OVF_EN
        ovf <= r_c ^ w_co;
`endif
      end
    end
  end
endmodule
